// File: rtl/race_ctl_pkg.sv
// Shared widths, state encoding and small helpers for the race game-flow controller.
package race_ctl_pkg;

  localparam int POS_W       = 11;
  localparam int TIME_W      = 16;
  localparam int LAP_W       = 2;
  localparam int CD_W        = 2;
  localparam int STATE_W     = 3;
  localparam int FRAME_CNT_W = 16;
  localparam int MAX_LAPS    = (1 << LAP_W) - 1;

  typedef enum logic [STATE_W-1:0] {
    ST_MENU      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_RACE      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_FINISH    = 3'd4
  } state_e;

  // Race timer sticks at all-ones instead of wrapping back to zero.
  function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
    return (&v) ? v : v + TIME_W'(1);
  endfunction

endpackage

// File: rtl/race_ctl_if.sv
// Frame/key/position inputs and layer/car/overlay outputs of the race controller.
interface race_ctl_if;
  import race_ctl_pkg::*;

  logic              frame_ended;
  logic              key_start;
  logic              key_pause;
  logic [POS_W-1:0]  xpos;
  logic [POS_W-1:0]  ypos;
  logic              bg_visible;
  logic              track_visible;
  logic              player_visible;
  logic              car_enable;
  logic [CD_W-1:0]   countdown;
  logic [LAP_W-1:0]  lap;
  logic [TIME_W-1:0] race_time;
  logic [STATE_W-1:0] state;

  // Environment side: timing/keyboard/car_ctl feed the controller.
  modport master (
    output frame_ended, key_start, key_pause, xpos, ypos,
    input  bg_visible, track_visible, player_visible, car_enable,
           countdown, lap, race_time, state
  );

  modport slave (
    input  frame_ended, key_start, key_pause, xpos, ypos,
    output bg_visible, track_visible, player_visible, car_enable,
           countdown, lap, race_time, state
  );

endinterface

// File: rtl/race_ctl_box_hit.sv
// Combinational inclusive rectangle test of a car position against fixed bounds.
module race_ctl_box_hit
  import race_ctl_pkg::*;
#(
  parameter int X0 = 0,
  parameter int X1 = 0,
  parameter int Y0 = 0,
  parameter int Y1 = 0
) (
  input  logic [POS_W-1:0] xpos,
  input  logic [POS_W-1:0] ypos,
  output logic             hit
);

  assign hit = (xpos >= POS_W'(X0)) && (xpos <= POS_W'(X1)) &&
               (ypos >= POS_W'(Y0)) && (ypos <= POS_W'(Y1));

endmodule

// File: rtl/race_ctl.sv
// Game-flow controller: menu -> countdown -> race -> finish, layer enables,
// car gating, lap counting from per-frame car position and a saturating timer.
module race_ctl
  import race_ctl_pkg::*;
#(
  parameter int COUNT_FRAMES  = 60,
  parameter int FINISH_FRAMES = 180,
  parameter int NUM_LAPS      = 3,
  parameter int FIN_X0 = 480,
  parameter int FIN_X1 = 543,
  parameter int FIN_Y0 = 600,
  parameter int FIN_Y1 = 615,
  parameter int CP_X0  = 480,
  parameter int CP_X1  = 543,
  parameter int CP_Y0  = 100,
  parameter int CP_Y1  = 163
) (
  input  logic       pclk,
  input  logic       rst,
  race_ctl_if.slave  bus
);

  if (NUM_LAPS < 1 || NUM_LAPS > MAX_LAPS) begin : g_bad_laps
    $error("race_ctl: NUM_LAPS must be in 1..%0d", MAX_LAPS);
  end

  localparam logic [FRAME_CNT_W-1:0] CNT_LAST = FRAME_CNT_W'(COUNT_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] FIN_LAST = FRAME_CNT_W'(FINISH_FRAMES - 1);
  localparam logic [LAP_W:0]         LAP_GOAL = (LAP_W + 1)'(NUM_LAPS);

  state_e              state_q, state_n;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_n;
  logic [CD_W-1:0]     cd_q, cd_n;
  logic [LAP_W-1:0]    lap_q, lap_n;
  logic [TIME_W-1:0]   time_q, time_n;
  logic                cp_q, cp_n;
  logic                fin_prev_q, fin_prev_n;
  logic                bg_q, track_q, player_q, car_en_q;
  logic                start_hist_q, pause_hist_q;
  logic                start_edge, pause_edge;
  logic                cp_hit, fin_hit;
  logic [LAP_W:0]      lap_plus;

  race_ctl_box_hit #(.X0(CP_X0), .X1(CP_X1), .Y0(CP_Y0), .Y1(CP_Y1)) u_cp_box (
    .xpos (bus.xpos),
    .ypos (bus.ypos),
    .hit  (cp_hit)
  );

  race_ctl_box_hit #(.X0(FIN_X0), .X1(FIN_X1), .Y0(FIN_Y0), .Y1(FIN_Y1)) u_fin_box (
    .xpos (bus.xpos),
    .ypos (bus.ypos),
    .hit  (fin_hit)
  );

  // History resets high so a key already held during reset never looks like a press.
  assign start_edge = bus.key_start & ~start_hist_q;
  assign pause_edge = bus.key_pause & ~pause_hist_q;
  assign lap_plus   = {1'b0, lap_q} + (LAP_W + 1)'(1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_n     = state_q;
    frame_cnt_n = frame_cnt_q;
    cd_n        = cd_q;
    lap_n       = lap_q;
    time_n      = time_q;
    cp_n        = cp_q;
    fin_prev_n  = fin_prev_q;

    unique case (state_q)
      ST_MENU: begin
        if (start_edge) begin
          state_n     = ST_COUNTDOWN;
          cd_n        = CD_W'(3);
          frame_cnt_n = '0;
          lap_n       = '0;
          time_n      = '0;
          cp_n        = 1'b0;
          // Seed with the grid position so a car parked on the line is not an entry.
          fin_prev_n  = fin_hit;
        end
      end

      ST_COUNTDOWN: begin
        if (bus.frame_ended) begin
          if (frame_cnt_q == CNT_LAST) begin
            frame_cnt_n = '0;
            cd_n        = cd_q - CD_W'(1);
            if (cd_q == CD_W'(1)) state_n = ST_RACE;
          end else begin
            frame_cnt_n = frame_cnt_q + FRAME_CNT_W'(1);
          end
        end
      end

      ST_RACE: begin
        if (bus.frame_ended) begin
          time_n     = sat_inc(time_q);
          fin_prev_n = fin_hit;
          if (cp_hit) cp_n = 1'b1;
          if (fin_hit && !fin_prev_q && cp_q) begin
            lap_n = lap_plus[LAP_W-1:0];
            cp_n  = 1'b0;
            if (lap_plus == LAP_GOAL) begin
              state_n     = ST_FINISH;
              frame_cnt_n = '0;
            end
          end
        end
        // The frame is processed first; a finishing frame swallows the pause.
        if (pause_edge && state_n == ST_RACE) state_n = ST_PAUSE;
      end

      ST_PAUSE: begin
        if (start_edge)      state_n = ST_MENU;
        else if (pause_edge) state_n = ST_RACE;
      end

      ST_FINISH: begin
        if (start_edge) begin
          state_n = ST_MENU;
        end else if (bus.frame_ended) begin
          if (frame_cnt_q == FIN_LAST) state_n = ST_MENU;
          else frame_cnt_n = frame_cnt_q + FRAME_CNT_W'(1);
        end
      end

      default: state_n = ST_MENU;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_MENU;
      frame_cnt_q  <= '0;
      cd_q         <= '0;
      lap_q        <= '0;
      time_q       <= '0;
      cp_q         <= 1'b0;
      fin_prev_q   <= 1'b0;
      start_hist_q <= 1'b1;
      pause_hist_q <= 1'b1;
      bg_q         <= 1'b1;
      track_q      <= 1'b0;
      player_q     <= 1'b0;
      car_en_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_n;
      frame_cnt_q  <= frame_cnt_n;
      cd_q         <= cd_n;
      lap_q        <= lap_n;
      time_q       <= time_n;
      cp_q         <= cp_n;
      fin_prev_q   <= fin_prev_n;
      start_hist_q <= bus.key_start;
      pause_hist_q <= bus.key_pause;
      bg_q         <= 1'b1;
      track_q      <= (state_n != ST_MENU);
      player_q     <= (state_n != ST_MENU);
      car_en_q     <= (state_n == ST_RACE);
    end
  end

  assign bus.bg_visible     = bg_q;
  assign bus.track_visible  = track_q;
  assign bus.player_visible = player_q;
  assign bus.car_enable     = car_en_q;
  assign bus.countdown      = cd_q;
  assign bus.lap            = lap_q;
  assign bus.race_time      = time_q;
  assign bus.state          = state_q;

endmodule

// File: tb/tb_race_ctl.sv
// Directed bench for race_ctl: a frame-level game model checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_race_ctl;
  import race_ctl_pkg::*;

  localparam int CF = 2;
  localparam int FF = 4;
  localparam int NL = 3;

  localparam int GX = 500, GY = 605;   // grid, inside the finish box
  localparam int CX = 500, CY = 120;   // checkpoint
  localparam int FX = 500, FY = 605;   // finish
  localparam int OX = 300, OY = 300;   // open track

  logic clk = 1'b0;
  logic rst = 1'b1;

  race_ctl_if bus ();

  race_ctl #(.COUNT_FRAMES(CF), .FINISH_FRAMES(FF), .NUM_LAPS(NL)) dut (
    .pclk (clk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_x = GX, cur_y = GY;

  // Model: game phase, frames seen in the current phase, laps, timer.
  int m_state = 0, m_frames = 0, m_lap = 0, m_time = 0;
  bit m_cp = 0, m_in_fin = 0, m_prev_start = 1, m_prev_pause = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_box(input int x, input int y, input int x0, input int x1,
                                input int y0, input int y1);
    return x >= x0 && x <= x1 && y >= y0 && y <= y1;
  endfunction

  initial begin : model_proc
    bit se, pe, fe, hc, hf, old_cp;
    int x, y;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_state = 0; m_frames = 0; m_lap = 0; m_time = 0;
        m_cp = 0; m_in_fin = 0; m_prev_start = 1; m_prev_pause = 1;
      end else begin
        se = bus.key_start && !m_prev_start;
        pe = bus.key_pause && !m_prev_pause;
        m_prev_start = bus.key_start;
        m_prev_pause = bus.key_pause;
        fe = bus.frame_ended;
        x  = int'(bus.xpos);
        y  = int'(bus.ypos);
        hc = in_box(x, y, 480, 543, 100, 163);
        hf = in_box(x, y, 480, 543, 600, 615);
        case (m_state)
          0: if (se) begin
               m_state = 1; m_frames = 0; m_lap = 0; m_time = 0; m_cp = 0; m_in_fin = hf;
             end
          1: if (fe) begin
               m_frames++;
               if (m_frames == 3 * CF) m_state = 2;
             end
          2: begin
               if (fe) begin
                 m_time = (m_time < 65535) ? m_time + 1 : 65535;
                 old_cp = m_cp;
                 if (hc) m_cp = 1;
                 if (hf && !m_in_fin && old_cp) begin
                   m_lap++;
                   m_cp = 0;
                 end
                 m_in_fin = hf;
               end
               if (m_lap == NL) begin
                 m_state = 4; m_frames = 0;
               end else if (pe) begin
                 m_state = 3;
               end
             end
          3: if (se) m_state = 0; else if (pe) m_state = 2;
          4: if (se) m_state = 0;
             else if (fe) begin
               m_frames++;
               if (m_frames == FF) m_state = 0;
             end
          default: m_state = 0;
        endcase
      end
    end
  end

  initial begin : compare_proc
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("m.state",  32'(bus.state), m_state);
        check("m.bg",     32'(bus.bg_visible), 1);
        check("m.track",  32'(bus.track_visible), (m_state != 0) ? 1 : 0);
        check("m.player", 32'(bus.player_visible), (m_state != 0) ? 1 : 0);
        check("m.car_en", 32'(bus.car_enable), (m_state == 2) ? 1 : 0);
        check("m.cd",     32'(bus.countdown), (m_state == 1) ? 3 - m_frames / CF : 0);
        check("m.lap",    32'(bus.lap), m_lap);
        check("m.time",   32'(bus.race_time), m_time);
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step(input bit fe, input bit ks, input bit kp);
    bus.frame_ended = fe;
    bus.key_start   = ks;
    bus.key_pause   = kp;
    bus.xpos        = POS_W'(cur_x);
    bus.ypos        = POS_W'(cur_y);
    @(negedge clk);
  endtask

  task automatic frame(input int x, input int y);
    cur_x = x; cur_y = y;
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic press_start();
    step(0, 1, 0);
    step(0, 0, 0);
  endtask

  task automatic press_pause();
    step(0, 0, 1);
    step(0, 0, 0);
  endtask

  task automatic run_countdown();
    for (int i = 0; i < 3 * CF; i++) frame(GX, GY);
  endtask

  initial begin : stimulus
    bus.frame_ended = 1'b0;
    bus.key_start   = 1'b1;   // held through reset
    bus.key_pause   = 1'b0;
    bus.xpos        = POS_W'(GX);
    bus.ypos        = POS_W'(GY);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst.state", 32'(bus.state), 0);
    check("rst.bg", 32'(bus.bg_visible), 1);
    check("rst.track", 32'(bus.track_visible), 0);
    check("rst.car_en", 32'(bus.car_enable), 0);
    check("rst.time", 32'(bus.race_time), 0);
    repeat (3) step(0, 1, 0);
    check("held_start_ignored", 32'(bus.state), 0);
    step(0, 0, 0);

    // Race 1: countdown timing, lap rules, then reset mid-race.
    press_start();
    check("cd.start_state", 32'(bus.state), 1);
    check("cd.start_digit", 32'(bus.countdown), 3);
    press_pause();
    check("cd.pause_ignored", 32'(bus.state), 1);
    frame(GX, GY); frame(GX, GY);
    check("cd.digit2", 32'(bus.countdown), 2);
    frame(GX, GY); frame(GX, GY);
    check("cd.digit1", 32'(bus.countdown), 1);
    frame(GX, GY);
    check("cd.still_cd", 32'(bus.state), 1);
    check("cd.car_off", 32'(bus.car_enable), 0);
    frame(GX, GY);
    check("race.state", 32'(bus.state), 2);
    check("race.car_en", 32'(bus.car_enable), 1);
    check("race.cd0", 32'(bus.countdown), 0);
    frame(GX, GY);
    check("grid_no_lap", 32'(bus.lap), 0);
    frame(OX, OY); frame(FX, FY);
    check("no_cp_no_lap", 32'(bus.lap), 0);
    frame(FX, FY);
    frame(CX, CY); frame(FX, FY);
    check("lap1", 32'(bus.lap), 1);
    frame(FX, FY);
    check("stay_in_fin", 32'(bus.lap), 1);
    frame(CX, CY); frame(OX, OY); frame(FX, FY);
    check("lap2", 32'(bus.lap), 2);
    check("time10", 32'(bus.race_time), 10);
    rst = 1'b1;
    step(0, 0, 0);
    check("midrst.state", 32'(bus.state), 0);
    check("midrst.lap", 32'(bus.lap), 0);
    check("midrst.time", 32'(bus.race_time), 0);
    check("midrst.player", 32'(bus.player_visible), 0);
    check("midrst.car_en", 32'(bus.car_enable), 0);
    rst = 1'b0;
    step(0, 0, 0);

    // Race 2: pause freezes the timer, simultaneous pause/frame, finish timing.
    cur_x = GX; cur_y = GY;
    press_start();
    run_countdown();
    for (int i = 0; i < 100; i++) frame(OX, OY);
    check("time100", 32'(bus.race_time), 100);
    press_pause();
    check("paused", 32'(bus.state), 3);
    check("paused.car_off", 32'(bus.car_enable), 0);
    for (int i = 0; i < 10; i++) frame(OX, OY);
    check("paused.time", 32'(bus.race_time), 100);
    press_pause();
    check("resumed", 32'(bus.state), 2);
    step(1, 0, 1);
    step(0, 0, 0);
    check("pf.time", 32'(bus.race_time), 101);
    check("pf.state", 32'(bus.state), 3);
    press_pause();
    frame(CX, CY); frame(FX, FY);
    frame(CX, CY); frame(FX, FY);
    check("r2.lap2", 32'(bus.lap), 2);
    frame(CX, CY);
    cur_x = FX; cur_y = FY;
    step(1, 0, 1);
    step(0, 0, 0);
    check("finish.state", 32'(bus.state), 4);
    check("finish.lap", 32'(bus.lap), 3);
    check("finish.car_off", 32'(bus.car_enable), 0);
    check("finish.time", 32'(bus.race_time), 107);
    frame(FX, FY); frame(FX, FY); frame(FX, FY);
    check("finish.hold", 32'(bus.state), 4);
    frame(FX, FY);
    check("finish.to_menu", 32'(bus.state), 0);
    check("menu.lap_kept", 32'(bus.lap), 3);

    // Race 3: start+pause together while paused goes to the menu.
    press_start();
    check("r3.lap_clear", 32'(bus.lap), 0);
    run_countdown();
    frame(OX, OY);
    press_pause();
    step(0, 1, 1);
    step(0, 0, 0);
    check("pause_start_menu", 32'(bus.state), 0);

    // Race 4: timer saturation, then early finish exit on start.
    cur_x = GX; cur_y = GY;
    press_start();
    run_countdown();
    press_start();
    check("start_in_race_ignored", 32'(bus.state), 2);
    cur_x = OX; cur_y = OY;
    for (int i = 0; i < 65534; i++) step(1, 0, 0);
    step(0, 0, 0);
    check("time_fffe", 32'(bus.race_time), 32'hFFFE);
    frame(OX, OY); frame(OX, OY); frame(OX, OY);
    check("time_sat", 32'(bus.race_time), 32'hFFFF);
    for (int i = 0; i < NL; i++) begin
      frame(CX, CY);
      frame(FX, FY);
    end
    check("r4.finish", 32'(bus.state), 4);
    check("r4.time_held", 32'(bus.race_time), 32'hFFFF);
    press_start();
    check("r4.early_exit", 32'(bus.state), 0);
    step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/race_ctl.md
Name: race_ctl

Overview:
Game-flow controller sequencing the xga drawing pipeline and car control for the racer. Walks menu -> countdown -> race -> finish and drives the layer-visibility flags consumed by draw_img stages. Gates car_ctl movement and counts laps from car position sampled once per frame. Keeps a saturating race timer in frames. Sits on the 65 MHz pixel clock next to car_ctl, taking keys from the keyboard block.

Parameters:
COUNT_FRAMES, 60, frames per countdown step
FINISH_FRAMES, 180, frames FINISH is held before returning to MENU
NUM_LAPS, 3, laps to win (1..3)
FIN_X0/FIN_X1/FIN_Y0/FIN_Y1, 480/543/600/615, finish-line box, inclusive
CP_X0/CP_X1/CP_Y0/CP_Y1, 480/543/100/163, checkpoint box, inclusive

Ports:
pclk  in  1  pixel clock, 65 MHz
rst  in  1  asynchronous reset, active-high
frame_ended  in  1  one-cycle pulse per frame from xga_timing
key_start  in  1  start/enter key level
key_pause  in  1  pause key level
xpos  in  11  car x position, valid on frame_ended
ypos  in  11  car y position, valid on frame_ended
bg_visible  out  1  background layer enable
track_visible  out  1  track layer enable
player_visible  out  1  car layer enable
car_enable  out  1  car_ctl may move car
countdown  out  2  current countdown digit (3..1, 0 otherwise)
lap  out  2  completed laps
race_time  out  16  frames elapsed in RACE, saturating
state  out  3  encoded state for debug/overlay

Behaviour:
- One clock, pclk; all flops reset asynchronously on rst high. Reset values: state=MENU, bg_visible=1, track_visible=0, player_visible=0, car_enable=0, countdown=0, lap=0, race_time=0, internal counters/flags 0.
- All outputs registered; take effect the cycle after the causing event.
- Keys: rising-edge detect via 1-flop history per key (history resets to 1, so a key held through reset is ignored). Levels are already synchronous to pclk.
- States (encoding: MENU=0, COUNTDOWN=1, RACE=2, PAUSE=3, FINISH=4):
  MENU: bg only. Start edge -> COUNTDOWN, countdown=3, frame counter=0, lap=0, race_time=0, checkpoint flag=0.
  COUNTDOWN: bg+track+player, car_enable=0. Each frame_ended increments frame counter; at COUNT_FRAMES-1 wrap to 0 and decrement countdown; on the wrap when countdown=1 -> RACE, countdown=0. Keys ignored.
  RACE: all layers, car_enable=1. Each frame_ended: race_time+1 saturating at 16'hFFFF; position checks below. Pause edge -> PAUSE.
  PAUSE: all layers, car_enable=0, race_time frozen, frame_ended ignored. Pause edge -> RACE. Start edge -> MENU.
  FINISH: all layers, car_enable=0, race_time and lap held. FINISH_FRAMES frame_ended pulses -> MENU; start edge exits early.
- Position checks (RACE, on frame_ended, compare registered xpos/ypos, inclusive bounds):
  - in checkpoint box -> checkpoint flag=1.
  - entry into finish box (inside now, outside at previous sample) with flag=1 -> lap+1, flag=0; if new lap == NUM_LAPS -> FINISH same update.
  - entry with flag=0 (reversing, start grid) -> no count.
  - previous-sample "inside finish" flag is cleared on COUNTDOWN entry to the computed grid status, so starting on the line does not count.
- Simultaneous: pause edge and frame_ended in same cycle in RACE -> frame processed first (timer/lap update), then PAUSE; if that frame finishes the race, FINISH wins and pause is dropped. Start and pause edges together in PAUSE -> MENU.
- Reset mid-operation returns to MENU with all counters cleared, no residual lap/timer.
- lap width 2 bits; NUM_LAPS>3 illegal (elaboration assertion).

Decomposition:
- race_pkg: state encoding localparams, NUM_LAPS bound, box-check widths.
- One sub-module: box_hit (combinational inclusive rectangle compare, parameterised bounds), instanced twice (checkpoint, finish). Edge detectors and frame divider stay inline.

Test Plan:
- Reset while in RACE with lap=2 -> next cycle state=0, lap=0, race_time=0, bg_visible=1, track/player_visible=0, car_enable=0.
- Start pulse in MENU, COUNT_FRAMES=2 -> countdown 3,2,1 each 2 frames, RACE after 6 frame_ended pulses, car_enable=1 one cycle after the 6th.
- In RACE drive positions checkpoint(500,120) -> finish(500,605) three times, NUM_LAPS=3 -> lap 1,2, then FINISH with lap=3, car_enable=0.
- Finish entry without checkpoint, and staying inside finish box across frames -> lap unchanged.
- Pause edge at race_time=100, 10 frames, pause again -> race_time resumes from 100; pause+frame_ended same cycle -> race_time=101 then PAUSE.
- Force race_time=16'hFFFE, 3 frames -> holds 16'hFFFF; FINISH with FINISH_FRAMES=4 -> MENU after 4 frames, or immediately after start edge.
